// File: rtl/boothmult_pkg.sv
// boothmult_pkg: shared state encoding, recoded-digit type and step count for boothmult_r4
package boothmult_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef struct packed {
    logic zero;
    logic neg;
    logic dbl;
  } digit_t;
  function automatic int booth_steps(input int n);
    return n / 2 + 1;
  endfunction
endpackage

// File: rtl/boothmult_r4_recoder.sv
// booth_r4_recoder: radix-4 Booth recoding of one 3-bit multiplier window
//   win  in   3  {b(2i+1), b(2i), b(2i-1)}
//   dig  out  3  {zero, neg, dbl}: digit is 0, +-M or +-2M
module booth_r4_recoder
  import boothmult_pkg::*;
(
  input  logic [2:0] win,
  output digit_t     dig
);
  always_comb begin
    dig.zero = (win == 3'b000) || (win == 3'b111);
    dig.neg  = win[2] && !dig.zero;
    dig.dbl  = (win == 3'b011) || (win == 3'b100);
  end
endmodule

// File: rtl/boothmult_r4.sv
// boothmult_r4: sequential radix-4 Booth multiplier, signed/unsigned per request
//   Clock in, nReset in (async active-low), op1/op2 in N_LEN, Signed in, Request in,
//   Busy out, Done out, Result out 2*N_LEN.
//   BOOTHMULT_ACC_EN adds input Accumulate: Result becomes Result_prev + product.
module boothmult_r4
  import boothmult_pkg::*;
#(
  parameter int N_LEN = 8
) (
  input  logic               Clock,
  input  logic               nReset,
  input  logic [N_LEN-1:0]   op1,
  input  logic [N_LEN-1:0]   op2,
  input  logic               Signed,
  input  logic               Request,
`ifdef BOOTHMULT_ACC_EN
  input  logic               Accumulate,
`endif
  output logic               Busy,
  output logic               Done,
  output logic [2*N_LEN-1:0] Result
);
  localparam int W = N_LEN + 2;
  localparam int STEPS = booth_steps(N_LEN);
  localparam int CW = $clog2(STEPS + 1);
  state_t state, state_nx;
  logic [W-1:0] m, q;
  logic q_m1;
  logic [W+1:0] acc, mag, addend, sum;
  logic [CW-1:0] cnt;
  logic [2*N_LEN-1:0] prod;
  logic accept, last;
  digit_t dig;
`ifdef BOOTHMULT_ACC_EN
  logic acc_en;
`endif
  booth_r4_recoder u_rec (
    .win({q[1:0], q_m1}),
    .dig(dig)
  );
  assign accept = Request && (state != RUN);
  assign last   = (state == RUN) && (cnt == CW'(STEPS - 1));
  assign mag    = dig.dbl ? {m[W-1], m, 1'b0} : {{2{m[W-1]}}, m};
  assign addend = dig.zero ? '0 : dig.neg ? -mag : mag;
  assign sum    = acc + addend;
  // {acc, q} shifted right by 2 holds the product; keep its low 2*N_LEN bits
  assign prod   = {sum[W-3:0], q[W-1:2]};
  always_ff @(posedge Clock or negedge nReset)
    if (!nReset) state <= IDLE;
    else state <= state_nx;
  always_comb state_nx = accept ? RUN : last ? DONE : state;
  always_comb begin
    Busy = (state == RUN);
    Done = (state == DONE);
  end
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      m      <= '0;
      q      <= '0;
      q_m1   <= 1'b0;
      acc    <= '0;
      cnt    <= '0;
      Result <= '0;
`ifdef BOOTHMULT_ACC_EN
      acc_en <= 1'b0;
`endif
    end else if (accept) begin
      m    <= {{2{Signed & op1[N_LEN-1]}}, op1};
      q    <= {{2{Signed & op2[N_LEN-1]}}, op2};
      q_m1 <= 1'b0;
      acc  <= '0;
      cnt  <= '0;
`ifdef BOOTHMULT_ACC_EN
      acc_en <= Accumulate;
`endif
    end else if (state == RUN) begin
      acc  <= {{2{sum[W+1]}}, sum[W+1:2]};
      q    <= {sum[1:0], q[W-1:2]};
      q_m1 <= q[1];
      cnt  <= cnt + 1'b1;
`ifdef BOOTHMULT_ACC_EN
      if (last) Result <= acc_en ? Result + prod : prod;
`else
      if (last) Result <= prod;
`endif
    end
  end
endmodule

// File: tb/tb_boothmult_r4.sv
// tb_boothmult_r4: directed and random checks of boothmult_r4 against a behavioural model
module tb_boothmult_r4;
  logic        Clock = 1'b0;
  logic        nReset = 1'b0;
  logic [7:0]  op1 = '0, op2 = '0;
  logic        Signed = 1'b0, Request = 1'b0, Accumulate = 1'b0;
  logic        Busy, Done;
  logic [15:0] Result;
  int n_checks = 0, n_errors = 0;
  logic en_cmp = 1'b0;
  logic m_busy = 1'b0, m_done = 1'b0;
  logic [15:0] m_res = '0, m_pend = '0;
  int m_cnt = 0;

  boothmult_r4 #(.N_LEN(8)) dut (
    .Clock(Clock),
    .nReset(nReset),
    .op1(op1),
    .op2(op2),
    .Signed(Signed),
    .Request(Request),
`ifdef BOOTHMULT_ACC_EN
    .Accumulate(Accumulate),
`endif
    .Busy(Busy),
    .Done(Done),
    .Result(Result)
  );

  always #50 Clock = ~Clock;

  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b, input logic s);
    int ai, bi;
    ai = (s && a[7]) ? int'(a) - 256 : int'(a);
    bi = (s && b[7]) ? int'(b) - 256 : int'(b);
    return 16'(ai * bi);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a request accepted when idle produces its product 5 edges later
  always @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_res  = '0;
      m_cnt  = 0;
    end else if (Request && !m_busy) begin
      m_pend = ref_mul(op1, op2, Signed);
`ifdef BOOTHMULT_ACC_EN
      if (Accumulate) m_pend = m_pend + m_res;
`endif
      m_cnt  = 5;
      m_busy = 1'b1;
      m_done = 1'b0;
    end else if (m_busy) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_busy = 1'b0;
        m_done = 1'b1;
        m_res  = m_pend;
      end
    end
  end

  always @(negedge Clock)
    if (en_cmp) begin
      chk("busy", 32'(Busy), 32'(m_busy));
      chk("done", 32'(Done), 32'(m_done));
      chk("result", 32'(Result), 32'(m_res));
    end

  task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                        input logic s, input logic ac, input logic [15:0] exp);
    int cnt, busy_cnt;
    @(negedge Clock);
    op1 = a; op2 = b; Signed = s; Accumulate = ac; Request = 1'b1;
    @(negedge Clock);
    Request = 1'b0;
    busy_cnt = int'(Busy);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge Clock);
      cnt++;
      #1;
      if (Done) break;
      if (Busy) busy_cnt++;
    end
    chk({name, "_latency"}, 32'(cnt), 32'd5);
    chk({name, "_busy_cycles"}, 32'(busy_cnt), 32'd5);
    chk(name, 32'(Result), 32'(exp));
  endtask

  initial begin
    repeat (2) @(negedge Clock);
    chk("reset_busy", 32'(Busy), 32'd0);
    chk("reset_done", 32'(Done), 32'd0);
    chk("reset_result", 32'(Result), 32'd0);
    nReset = 1'b1;
    en_cmp = 1'b1;
    run_op("neg128_sq", 8'h80, 8'h80, 1'b1, 1'b0, 16'h4000);
    run_op("ff_unsigned", 8'hFF, 8'hFF, 1'b0, 1'b0, 16'hFE01);
    run_op("ff_signed", 8'hFF, 8'hFF, 1'b1, 1'b0, 16'h0001);
    run_op("m1_x_1", 8'hFF, 8'h01, 1'b1, 1'b0, 16'hFFFF);
    run_op("127_x_m128", 8'h7F, 8'h80, 1'b1, 1'b0, 16'hC080);
    run_op("zero", 8'h00, 8'h5A, 1'b1, 1'b0, 16'h0000);
    // request while busy is ignored, operand changes have no effect
    @(negedge Clock);
    op1 = 8'd3; op2 = 8'd5; Signed = 1'b0; Request = 1'b1;
    @(negedge Clock);
    Request = 1'b0; op1 = 8'd7; op2 = 8'd9;
    @(negedge Clock);
    Request = 1'b1;
    @(negedge Clock);
    Request = 1'b0;
    for (int i = 0; i < 20 && !Done; i++) @(negedge Clock);
    chk("busy_ignore", 32'(Result), 32'h000F);
    // asynchronous reset during step 2
    @(negedge Clock);
    op1 = 8'hFB; op2 = 8'd7; Signed = 1'b1; Request = 1'b1;
    @(negedge Clock);
    Request = 1'b0;
    @(posedge Clock);
    @(posedge Clock);
    #10 nReset = 1'b0;
    #1;
    chk("midreset_busy", 32'(Busy), 32'd0);
    chk("midreset_done", 32'(Done), 32'd0);
    chk("midreset_result", 32'(Result), 32'd0);
    @(posedge Clock);
    @(negedge Clock);
    nReset = 1'b1;
    run_op("after_reset", 8'd6, 8'd7, 1'b0, 1'b0, 16'h002A);
`ifdef BOOTHMULT_ACC_EN
    run_op("acc_base", 8'd3, 8'd4, 1'b0, 1'b0, 16'd12);
    run_op("acc_sum", 8'd5, 8'd6, 1'b0, 1'b1, 16'd42);
`endif
    for (int i = 0; i < 2000; i++) begin
      @(negedge Clock);
      Request = 1'($urandom_range(0, 1));
      op1 = 8'($urandom);
      op2 = 8'($urandom);
      Signed = 1'($urandom_range(0, 1));
      Accumulate = 1'($urandom_range(0, 1));
    end
    @(negedge Clock);
    Request = 1'b0;
    repeat (8) @(negedge Clock);
    en_cmp = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
